// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and the receive FSM state encoding
//
// Purpose: one home for values that the UART receive path and the register
// file must agree on.
// Contents: default bit period, LSR bit positions, rx FSM state type.
package uart_pkg;

    // 50 MHz system clock / 115200 baud
    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;

    // Line status register bit positions
    localparam int LSR_DR   = 0;
    localparam int LSR_OE   = 1;
    localparam int LSR_FE   = 3;
    localparam int LSR_THRE = 5;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead byte FIFO holding received UART characters
//
// Purpose: buffers complete receive bytes until the register file reads RHR.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_push, i_push_data  write one byte (accepted if not full, or if popping)
//   i_pop                drop the head entry (ignored when empty)
//   o_head               head byte, 8'h00 when empty
//   o_full, o_empty      occupancy flags
//   o_count              current occupancy, 0..DEPTH
module uart_rx_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [7:0]    i_push_data,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);

    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_push_data;
    end

    assign o_head  = o_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with receive FIFO and LSR-style status
//
// Purpose: mid-bit sampling of the RX pin, LSB-first frame assembly, byte
// buffering and sticky error flags for the UART register file.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_rx_serial      raw RX pin (asynchronous, idles high)
//   i_pop            RHR read: drop head byte
//   i_clear_err      clear sticky overrun / framing error
//   o_data           FIFO head byte (0 when empty)
//   o_data_ready     FIFO not empty
//   o_overrun        sticky: byte dropped on a full FIFO
//   o_frame_err      sticky: stop bit sampled low
//   o_rx_active      FSM not idle
//   o_rx_done        one-cycle pulse per frame with a valid stop bit
//   o_count          FIFO occupancy
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx_serial,
    input  logic                          i_pop,
    input  logic                          i_clear_err,
    output logic [7:0]                    o_data,
    output logic                          o_data_ready,
    output logic                          o_overrun,
    output logic                          o_frame_err,
    output logic                          o_rx_active,
    output logic                          o_rx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_e        state_q;
    logic             sync1_q, rx_s_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             rx_done_q, overrun_q, frame_err_q;

    logic             stop_sample, push, fifo_full, fifo_empty;
    logic             overrun_set, frame_err_set;

    // Two-flop synchronizer; resets to the idle line level so reset release
    // never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx_serial;
            rx_s_q  <= sync1_q;
        end
    end

    assign stop_sample   = (state_q == RX_STOP) && (clk_cnt_q == CNT_LAST);
    // Push straight from the stop-sample cycle so the byte appears on o_data
    // in the same cycle as the o_rx_done pulse.
    assign push          = stop_sample && rx_s_q;
    assign frame_err_set = stop_sample && !rx_s_q;
    assign overrun_set   = push && fifo_full && !i_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= RX_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    if (!rx_s_q) state_q <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt_q == CNT_HALF) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_q   <= rx_s_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == 3'd7) state_q <= RX_STOP;
                        else                   bit_idx_q <= bit_idx_q + 3'd1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == CNT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s_q) begin
                            rx_done_q <= 1'b1;
                            state_q   <= RX_IDLE;
                        end else begin
                            state_q   <= RX_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    // Hold off through a break so it is not decoded as 0x00 frames.
                    if (rx_s_q) state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    // Sticky flags: a set event beats a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (overrun_set)      overrun_q <= 1'b1;
            else if (i_clear_err) overrun_q <= 1'b0;
            if (frame_err_set)    frame_err_q <= 1'b1;
            else if (i_clear_err) frame_err_q <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_data (shift_q),
        .i_pop       (i_pop),
        .o_head      (o_data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (o_count)
    );

    assign o_data_ready = !fifo_empty;
    assign o_overrun    = overrun_q;
    assign o_frame_err  = frame_err_q;
    assign o_rx_active  = (state_q != RX_IDLE);
    assign o_rx_done    = rx_done_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking scoreboard bench for uart_rx
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       pop = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] o_data;
    logic       o_data_ready, o_overrun, o_frame_err, o_rx_active, o_rx_done;
    logic [3:0] o_count;

    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    logic       exp_fe = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_serial  (rx),
        .i_pop        (pop),
        .i_clear_err  (clr),
        .o_data       (o_data),
        .o_data_ready (o_data_ready),
        .o_overrun    (o_overrun),
        .o_frame_err  (o_frame_err),
        .o_rx_active  (o_rx_active),
        .o_rx_done    (o_rx_done),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_rx_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame starting just after a rising edge and updates the model.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        if (stop) begin
            exp_done++;
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else                      exp_ovr = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check(tag, o_data, e);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
    endtask

    task automatic status_check(input string tag);
        check({tag, "_count"}, o_count, exp_q.size());
        check({tag, "_ready"}, o_data_ready, exp_q.size() > 0);
        check({tag, "_ovr"}, o_overrun, exp_ovr);
        check({tag, "_fe"}, o_frame_err, exp_fe);
        check({tag, "_done"}, done_cnt, exp_done);
    endtask

    task automatic clear_pulse();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
    endtask

    initial begin
        logic [7:0] partial;

        // Reset state
        tick(3);
        check("rst_data", o_data, 8'h00);
        check("rst_active", o_rx_active, 1'b0);
        check("rst_rxdone", o_rx_done, 1'b0);
        status_check("rst");
        rst_n = 1'b1;
        tick(2);

        // Single frame with latency probe around the stop sample cycle
        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(154);
                check("t1_pre_ready", o_data_ready, 1'b0);
                tick(1);
                check("t1_ready_edge", o_data_ready, 1'b1);
                check("t1_done_edge", o_rx_done, 1'b1);
                check("t1_data_edge", o_data, 8'hA5);
                tick(1);
                check("t1_done_pulse", o_rx_done, 1'b0);
            end
        join
        tick(2);
        status_check("t1");
        pop_check("t1_pop");
        check("t1_empty_data", o_data, 8'h00);
        status_check("t1_after");

        // Glitch shorter than half a bit
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        check("t2_active", o_rx_active, 1'b0);
        status_check("t2");

        // Framing error, held-low line, recovery, clear
        send_frame(8'h3C, 1'b0);
        tick(40);
        check("t3_active_low", o_rx_active, 1'b1);
        status_check("t3_fe");
        rx = 1'b1;
        tick(4);
        check("t3_active_high", o_rx_active, 1'b0);
        send_frame(8'h11, 1'b1);
        tick(2);
        status_check("t3_ok");
        pop_check("t3_pop");
        clear_pulse();
        status_check("t3_clr");

        // Overrun: nine frames, no pops
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1);
            tick(2);
        end
        status_check("t4_full");
        for (int i = 0; i < 8; i++) pop_check("t4_pop");
        status_check("t4_drained");
        clear_pulse();
        status_check("t4_clr");

        // Full FIFO, pop coincides with the ninth stop sample
        for (int i = 0; i < 8; i++) begin
            send_frame(8'h80 + 8'(i), 1'b1);
            tick(2);
        end
        status_check("t5_full");
        fork
            send_frame(8'h99, 1'b1);
            begin
                tick(154);
                pop_check("t5_pop_coincide");
            end
        join
        tick(2);
        status_check("t5_after");
        for (int i = 0; i < 8; i++) pop_check("t5_pop");
        status_check("t5_drained");

        // Reset in the middle of a frame
        send_frame(8'h77, 1'b1);
        tick(2);
        status_check("t6_pre");
        partial = 8'h5A;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = partial[i];
            tick(CPB);
        end
        rx = partial[3];
        tick(CPB / 2);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
        check("t6_rst_data", o_data, 8'h00);
        check("t6_rst_active", o_rx_active, 1'b0);
        check("t6_rst_ready", o_data_ready, 1'b0);
        check("t6_rst_count", o_count, 4'd0);
        rx = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        send_frame(8'hC3, 1'b1);
        tick(2);
        check("t6_data", o_data, 8'hC3);
        status_check("t6_post");
        pop_check("t6_pop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receive half of the UART peripheral and the counterpart to the existing 8N1 transmitter. Samples the asynchronous RX pin at mid-bit, assembles 8N1 frames LSB-first, and buffers complete bytes in a small show-ahead FIFO. Provides RHR data and LSR-style status (data ready, overrun, framing error) to the memory-mapped UART register file.

Parameters:
CLKS_PER_BIT, 434, system clocks per bit (50 MHz / 115200); must be >= 4.
FIFO_DEPTH, 8, receive FIFO entries; must be a power of two >= 2.

Ports:
i_clk  in  1  system clock; all logic on the rising edge.
i_rst_n  in  1  asynchronous, active-low reset.
i_rx_serial  in  1  raw RX pin, asynchronous to i_clk; idles high.
i_pop  in  1  one-cycle pulse: the register file read RHR, so drop the head entry.
i_clear_err  in  1  one-cycle pulse: clears the sticky o_overrun and o_frame_err flags.
o_data  out  8  FIFO head byte (show-ahead); 8'h00 when the FIFO is empty.
o_data_ready  out  1  FIFO not empty (LSR bit 0).
o_overrun  out  1  sticky: a valid byte was dropped because the FIFO was full (LSR bit 1).
o_frame_err  out  1  sticky: a stop bit was sampled as 0 (LSR bit 3).
o_rx_active  out  1  high in every FSM state except IDLE.
o_rx_done  out  1  one-cycle pulse for each frame that ends with a valid stop bit.
o_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync-free deassert):
  - FSM goes to IDLE.
  - Both synchronizer flops go to 1.
  - Bit counter, bit index, shift register and FIFO pointers go to 0.
  - All outputs go to 0.
- Synchronizer: i_rx_serial passes through 2 flops; the FSM uses only the synced value, rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. clk_cnt counts 0..CLKS_PER_BIT-1.
  - IDLE: if rx_s==0, go to START with clk_cnt=0.
  - START: at clk_cnt==(CLKS_PER_BIT-1)/2:
    - rx_s==0: go to DATA, clk_cnt=0, bit_idx=0.
    - rx_s==1: glitch; return to IDLE with no side effects.
  - DATA: at clk_cnt==CLKS_PER_BIT-1:
    - Shift rx_s into bit[bit_idx] (LSB first) and set clk_cnt=0.
    - After bit_idx==7, go to STOP; otherwise increment bit_idx.
  - STOP: at clk_cnt==CLKS_PER_BIT-1:
    - rx_s==1: push the byte and pulse o_rx_done on the next cycle, then go to IDLE.
    - rx_s==0: set o_frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break from being decoded as back-to-back 0x00 frames.
- FIFO push/pop rules:
  - Push on a full FIFO with no pop in the same cycle: byte dropped, o_overrun set, o_rx_done still pulses.
  - Push and pop in the same cycle: both take effect, count unchanged, no overrun even when full.
  - Pop on an empty FIFO: ignored; pointers do not move.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_data, o_data_ready and o_count update the cycle after a push or pop.
- Flag priority: if a set event and i_clear_err occur in the same cycle, set wins.
- Latency: a pushed byte is visible on o_data exactly 1 cycle after the STOP sample cycle. The STOP sample is about 2 + 9.5*CLKS_PER_BIT cycles after the pin's falling edge.
- No parity support. Exactly one stop bit is checked; extra stop bits are absorbed in IDLE.

Decomposition:
- uart_pkg holds:
  - the rx FSM state encoding;
  - LSR bit-index constants: LSR_DR=0, LSR_OE=1, LSR_FE=3, LSR_THRE=5;
  - UART_CLKS_PER_BIT_DEFAULT=434.
- Sub-module uart_rx_fifo: a synchronous show-ahead FIFO with push/pop/full/empty/count. The FSM and flags stay in uart_rx.

Test Plan:
All tests use CLKS_PER_BIT=16 and FIFO_DEPTH=8.
- Frame 0xA5 with a valid stop bit -> exactly one o_rx_done pulse; o_data=0xA5, o_data_ready=1, o_count=1. Then pulse i_pop -> o_data=0x00, o_data_ready=0, o_count=0.
- Pin low for 5 cycles then high (glitch shorter than half a bit) -> FSM returns to IDLE; o_count=0, no flags, no o_rx_done.
- Frame 0x3C with stop bit 0, line held low 40 more cycles -> o_frame_err=1, o_count=0, o_rx_active=1 until the line rises. Then frame 0x11 -> received OK. Then i_clear_err -> o_frame_err=0.
- Nine frames 0x00..0x08 with no pops -> o_count=8, o_overrun=1. Eight pops return 0x00..0x07 in order, then o_data_ready=0.
- FIFO full, with i_pop coinciding with the 9th STOP sample cycle -> o_overrun=0, o_count stays 8, 9th byte stored last.
- Reset asserted mid-DATA of 0x5A -> all outputs 0 immediately. After release, a full frame 0xC3 -> o_data=0xC3, o_count=1.
